// File: rtl/dff_pkg.sv
// Shared helpers for the register pipeline: counter width and depth bound.
// Latency: none (elaboration-time constants only).
// Backpressure: not applicable.
package dff_pkg;

  // Smallest legal number of stages in a pipeline.
  localparam int DFF_MIN_DEPTH = 1;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register with async reset.
// Latency: 1 cycle from prev_* to stg_* when load is high.
// Backpressure: holds its contents while load is low; the top drives load.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_dat,
  output logic             stg_vld,
  output logic [WIDTH-1:0] stg_dat
);

  // Valid bit: flush empties the stage, otherwise it follows its source on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= 1'b0;
    end else if (flush) begin
      stg_vld <= 1'b0;
    end else if (load) begin
      stg_vld <= prev_vld;
    end
  end

  // Data register: only real words are captured, so bubbles never overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_dat <= RESET_VAL;
    end else if (load && prev_vld && !flush) begin
      stg_dat <= prev_dat;
    end
  end

endmodule

// File: rtl/dff_pipe_reg.sv
// Bubble-collapsing register pipeline of DEPTH stages with valid/ready at both ends.
// Latency: a word offered to an empty pipe shows out_valid DEPTH edges later.
// Backpressure: combinational ready chain; only the full tail of the pipe stalls.
module dff_pipe_reg
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  if (WIDTH < 1 || DEPTH < DFF_MIN_DEPTH) begin : g_param_check
    $error("dff_pipe_reg: WIDTH and DEPTH must both be at least 1");
  end

  logic [DEPTH-1:0] stg_vld;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [DEPTH:0]   stg_rdy;
  logic             in_hs;
  logic             out_hs;

  // Ready chain from the output back to the input: a stage can load if it is
  // empty or if the stage after it is moving.
  always_comb begin
    stg_rdy        = '0;
    stg_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      stg_rdy[i] = ~stg_vld[i] | stg_rdy[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             prev_vld;
    logic [WIDTH-1:0] prev_dat;

    if (i == 0) begin : g_head
      assign prev_vld = in_valid;
      assign prev_dat = in_data;
    end else begin : g_link
      assign prev_vld = stg_vld[i-1];
      assign prev_dat = stg_dat[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (stg_rdy[i]),
      .prev_vld (prev_vld),
      .prev_dat (prev_dat),
      .stg_vld  (stg_vld[i]),
      .stg_dat  (stg_dat[i])
    );
  end

  assign in_ready  = stg_rdy[0] & ~flush;
  assign out_valid = stg_vld[DEPTH-1];
  assign out_data  = stg_dat[DEPTH-1];
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // Occupancy tracks handshakes rather than summing valid bits; flush empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_hs && !out_hs) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_hs && !in_hs) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Scoreboard bench for dff_pipe_reg: a DEPTH=3 byte pipe and a DEPTH=1 bit slice.
// Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
// The reference is a FIFO of accepted words plus a count of stored words.
module tb_dff_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;

  logic       flush3 = 1'b0, iv3 = 1'b0, or3 = 1'b0;
  logic       ir3, ov3;
  logic [7:0] id3 = 8'h00, od3;
  logic [1:0] occ3;

  logic       flush1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
  logic       ir1, ov1;
  logic [0:0] id1 = 1'b0, od1;
  logic [0:0] occ1;

  dff_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .occupancy(occ3)
  );

  dff_pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(occ1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: words accepted but not yet delivered, in order.
  logic [7:0] q3[$];
  logic       q1[$];
  int         acc3 = 0, out3 = 0, acc1 = 0, out1 = 0;

  // Monitor for the 3-deep pipe: in_ready is free whenever some slot is empty
  // or the head is leaving; data must leave in arrival order.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (rst) begin
      q3.delete();
    end else begin
      chk("occ3", 32'(occ3), 32'(q3.size()));
      chk("in_ready3", 32'(ir3), 32'(!flush3 && (q3.size() < 3 || or3)));
      if (q3.size() == 0) chk("idle_out_valid3", 32'(ov3), 32'd0);
      if (ov3 && or3) begin
        out3++;
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL data3: word delivered %0h but none expected", od3);
        end else begin
          exp_d = q3.pop_front();
          if (od3 !== exp_d) begin
            errors++;
            $display("FAIL data3: got %0h expected %0h", od3, exp_d);
          end
        end
      end
      if (iv3 && ir3) begin
        q3.push_back(id3);
        acc3++;
      end
      if (flush3) q3.delete();
    end
  end

  // Monitor for the single-entry slice: it is visible as soon as it is stored.
  always @(negedge clk) begin
    logic exp_b;
    if (rst) begin
      q1.delete();
    end else begin
      chk("occ1", 32'(occ1), 32'(q1.size()));
      chk("out_valid1", 32'(ov1), 32'(q1.size() != 0));
      chk("in_ready1", 32'(ir1), 32'(!flush1 && (q1.size() == 0 || or1)));
      if (ov1 && or1) begin
        out1++;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL data1: word delivered %0h but none expected", od1);
        end else begin
          exp_b = q1.pop_front();
          if (od1 !== exp_b) begin
            errors++;
            $display("FAIL data1: got %0h expected %0h", od1, exp_b);
          end
        end
      end
      if (iv1 && ir1) begin
        q1.push_back(id1[0]);
        acc1++;
      end
      if (flush1) q1.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, o0, lat;

    // Reset asserted in the middle of a clock phase takes effect at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov3), 32'd0);
    chk("rst_out_data", 32'(od3), 32'hA5);
    chk("rst_occ", 32'(occ3), 32'd0);
    chk("rst_out_data1", 32'(od1), 32'd1);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(ir3), 32'd1);

    // Latency: count edges from the cycle the word is offered to out_valid.
    step();
    iv3 = 1'b1;
    id3 = 8'h55;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      lat++;
      iv3 = 1'b0;
      if (ov3) break;
    end
    chk("latency3", 32'(lat), 32'd3);
    chk("latency3_data", 32'(od3), 32'h55);
    or3 = 1'b1;
    step();

    // Streaming 01..10 with the sink always ready.
    a0 = acc3;
    o0 = out3;
    for (int i = 1; i <= 16; i++) begin
      iv3 = 1'b1;
      id3 = 8'(i);
      step();
      if (i >= 3) begin
        chk("stream_out_valid", 32'(ov3), 32'd1);
        chk("stream_occ", 32'(occ3), 32'd3);
      end
    end
    iv3 = 1'b0;
    repeat (5) step();
    chk("stream_accepted", 32'(acc3 - a0), 32'd16);
    chk("stream_delivered", 32'(out3 - o0), 32'd16);

    // Back-pressure: only three of five offered words fit.
    or3 = 1'b0;
    a0 = acc3;
    for (int i = 0; i < 5; i++) begin
      iv3 = 1'b1;
      id3 = 8'($urandom);
      step();
    end
    chk("bp_accepted", 32'(acc3 - a0), 32'd3);
    chk("bp_in_ready", 32'(ir3), 32'd0);
    chk("bp_occ", 32'(occ3), 32'd3);
    or3 = 1'b1;
    #1;
    chk("full_pass_in_ready", 32'(ir3), 32'd1);
    a0 = acc3;
    o0 = out3;
    id3 = 8'($urandom);
    step();
    chk("full_pass_in", 32'(acc3 - a0), 32'd1);
    chk("full_pass_out", 32'(out3 - o0), 32'd1);
    chk("full_pass_occ", 32'(occ3), 32'd3);

    // Flush a full pipe: head word is delivered, new word is refused.
    a0 = acc3;
    o0 = out3;
    flush3 = 1'b1;
    iv3 = 1'b1;
    id3 = 8'hEE;
    step();
    flush3 = 1'b0;
    iv3 = 1'b0;
    or3 = 1'b0;
    chk("flush_delivered", 32'(out3 - o0), 32'd1);
    chk("flush_refused", 32'(acc3 - a0), 32'd0);
    chk("flush_out_valid", 32'(ov3), 32'd0);
    chk("flush_occ", 32'(occ3), 32'd0);

    // Bubble collapse with the sink stalled.
    iv3 = 1'b1; id3 = 8'hB1; step();
    iv3 = 1'b0;              step();
    iv3 = 1'b1; id3 = 8'hB2; step();
    iv3 = 1'b0;              step();
    chk("bubble_out_valid", 32'(ov3), 32'd1);
    chk("bubble_occ", 32'(occ3), 32'd2);
    chk("bubble_in_ready", 32'(ir3), 32'd1);
    a0 = acc3;
    iv3 = 1'b1; id3 = 8'hB3; step();
    iv3 = 1'b0;
    chk("bubble_third_in", 32'(acc3 - a0), 32'd1);
    chk("bubble_full_in_ready", 32'(ir3), 32'd0);
    or3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bubble_contig", 32'(ov3), 32'd1);
      step();
    end
    chk("bubble_drained", 32'(ov3), 32'd0);

    // Reset in the middle of traffic drops everything immediately.
    or3 = 1'b0;
    iv3 = 1'b1; id3 = 8'hC1; step();
    id3 = 8'hC2; step();
    iv3 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov3), 32'd0);
    chk("midrst_out_data", 32'(od3), 32'hA5);
    chk("midrst_occ", 32'(occ3), 32'd0);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ir3), 32'd1);

    // Single-entry slice: stored on the next edge, ready only via out_ready.
    step();
    or1 = 1'b0;
    iv1 = 1'b1;
    id1 = 1'b0;
    step();
    chk("d1_latency", 32'(ov1), 32'd1);
    chk("d1_full_in_ready", 32'(ir1), 32'd0);
    or1 = 1'b1;
    #1;
    chk("d1_pass_in_ready", 32'(ir1), 32'd1);
    for (int i = 0; i < 20; i++) begin
      or1 = i[0];
      id1 = 1'($urandom);
      step();
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    step();

    // Random traffic on both pipes, with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      iv3    = 1'($urandom_range(0, 1));
      or3    = 1'($urandom_range(0, 1));
      flush3 = ($urandom_range(0, 19) == 0);
      id3    = 8'($urandom);
      iv1    = 1'($urandom_range(0, 1));
      or1    = 1'($urandom_range(0, 1));
      flush1 = ($urandom_range(0, 19) == 0);
      id1    = 1'($urandom);
      step();
    end
    iv3 = 1'b0; or3 = 1'b1; flush3 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; flush1 = 1'b0;
    repeat (5) step();
    chk("drain_left3", 32'(q3.size()), 32'd0);
    chk("drain_out_valid3", 32'(ov3), 32'd0);
    chk("drain_left1", 32'(q1.size()), 32'd0);
    chk("drain_out_valid1", 32'(ov1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
